// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding,
// counter widths and the load-use hazard predicate.
package pipe_ctrl_pkg;

    localparam int CNT_W  = 16;
    localparam int WAIT_W = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } ctrl_state_t;

    // A load in EX whose result the ID instruction needs; r0 never creates a dependency.
    function automatic logic load_use_hazard(
        input logic       ex_mem_r,
        input logic [4:0] ex_dest,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_use_rt
    );
        return ex_mem_r && (ex_dest != 5'd0) &&
               ((ex_dest == id_rs) || (id_use_rt && (ex_dest == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter with enable and async clear that sticks at all-ones.
module sat_counter16
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller beside the EX stage: drives register enables and
// bubbles for memory stalls, taken branches and load-use hazards.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_useRt,
    input  logic             EX_MemR,
    input  logic [4:0]       EX_dest,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = TIMEOUT[WAIT_W-1:0];

    ctrl_state_t       state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_err_reg;
    logic              advance;
    logic              hazard;
    logic              branch_flush;

    assign hazard = load_use_hazard(EX_MemR, EX_dest, ID_Rs, ID_Rt, ID_useRt);

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        advance       = 1'b0;
        case (state_reg)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                    advance       = 1'b1;
                end else if (wait_cnt_reg == TIMEOUT_CNT) begin
                    state_next = ERR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Outputs stay low for the whole reset pulse, not just until the next edge.
    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        branch_flush = 1'b0;
        if (advance && !rst) begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (branch_taken) begin
                pc_en        = 1'b1;
                ifid_en      = 1'b1;
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                branch_flush = 1'b1;
            end else if (hazard) begin
                idex_flush = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_next == ERR) begin
                mem_err_reg <= 1'b1;
            end
        end
    end

    assign mem_err = mem_err_reg;

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (!pc_en),
        .count (stall_cnt)
    );

    sat_counter16 u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (branch_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic,
// expected responses from a behavioural model queued and checked by a monitor.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ID_Rs = '0, ID_Rt = '0, EX_dest = '0;
    logic        ID_useRt = 1'b0, EX_MemR = 1'b0, branch_taken = 1'b0;
    logic        mem_req = 1'b0, mem_ready = 1'b0;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic [15:0] stall_cnt, flush_cnt;
    logic        mem_err;

    pipe_hazard_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_useRt(ID_useRt),
        .EX_MemR(EX_MemR), .EX_dest(EX_dest), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  ctrl;   // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
        logic [15:0] stall;
        logic [15:0] flush;
        logic        err;
        logic        quiet;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: waiting on memory, timed out, wait-cycle count, counters.
    bit   m_wait = 0, m_fail = 0;
    int   m_wcnt = 0, m_stall = 0, m_flush = 0;

    task automatic apply(input logic r, input logic mr, input logic mrdy, input logic br,
                         input logic memr, input logic [4:0] dest, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic quiet);
        exp_t       e;
        logic       hz, mstall, brc;
        logic [6:0] c;
        @(posedge clk);
        #1;
        rst = r; mem_req = mr; mem_ready = mrdy; branch_taken = br;
        EX_MemR = memr; EX_dest = dest; ID_Rs = rs; ID_Rt = rt; ID_useRt = urt;
        hz  = memr && (dest != 0) && ((dest == rs) || (urt && (dest == rt)));
        brc = 1'b0;
        c   = 7'b0;
        if (r) begin
            m_wait = 0; m_fail = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
        end else if (!m_fail) begin
            mstall = m_wait ? !mrdy : (mr && !mrdy);
            if (mstall)    c = 7'b0000000;
            else if (br) begin c = 7'b1111111; brc = 1'b1; end
            else if (hz)   c = 7'b0011101;
            else           c = 7'b1111100;
        end
        e.ctrl = c; e.stall = 16'(m_stall); e.flush = 16'(m_flush);
        e.err = m_fail; e.quiet = quiet;
        q.push_back(e);
        if (!r) begin
            if (!c[6] && m_stall < 65535) m_stall++;
            if (brc && m_flush < 65535) m_flush++;
            if (!m_fail) begin
                if (m_wait) begin
                    if (mrdy) m_wait = 0;
                    else if (m_wcnt == TMO) begin m_fail = 1; m_wait = 0; end
                    else m_wcnt++;
                end else if (mr && !mrdy) begin
                    m_wait = 1; m_wcnt = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    // Monitor: the DUT presents outputs every cycle; check mid-cycle.
    initial begin
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
                if (act !== e.ctrl) begin
                    miscompares++;
                    $display("FAIL ctrl txn %0d: got %b want %b", vectors, act, e.ctrl);
                end
                if (stall_cnt !== e.stall) begin
                    miscompares++;
                    $display("FAIL stall_cnt txn %0d: got %h want %h", vectors, stall_cnt, e.stall);
                end
                if (flush_cnt !== e.flush) begin
                    miscompares++;
                    $display("FAIL flush_cnt txn %0d: got %h want %h", vectors, flush_cnt, e.flush);
                end
                if (mem_err !== e.err) begin
                    miscompares++;
                    $display("FAIL mem_err txn %0d: got %b want %b", vectors, mem_err, e.err);
                end
                if (!e.quiet)
                    $display("txn %0d ctrl=%b stall=%h flush=%h err=%b",
                             vectors, act, stall_cnt, flush_cnt, mem_err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        apply(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        apply(1, 1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0);
        idle(1);
        // Load-use on Rs, then via Rt, then Rt ignored when not used
        apply(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
        apply(0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0);
        apply(0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0);
        // r0 destination never stalls
        apply(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
        // Branch beats load-use
        apply(0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0);
        // Memory stall beats branch; three freezes then release with a branch
        apply(0, 1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0);
        apply(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        apply(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        apply(0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        // Completing wait cycle with a load-use hazard
        apply(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        apply(0, 1, 1, 0, 1, 5'd3, 5'd0, 5'd3, 1, 0);
        idle(1);
        // Timeout into the error state, held, then cleared by reset
        for (int i = 0; i < 8; i++) apply(0, 1, 0, i[0], 0, 5'd0, 5'd0, 5'd0, 0, 0);
        apply(0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        apply(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);
        // Reset in the middle of a wait
        apply(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        apply(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        apply(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        apply(0, 0, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0, 0);
        idle(1);
        // Random traffic; reset whenever the model has timed out
        for (int i = 0; i < 1500; i++) begin
            logic r;
            r = m_fail && ($urandom_range(0, 3) == 0);
            apply(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 1), 0);
        end
        // Saturation: sit in the error state long enough to pin stall_cnt at all-ones
        apply(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 65545; i++)
            apply(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, (i < 65535) ? 1'b1 : 1'b0);
        apply(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, range 2..255: maximum MEM_WAIT cycles before error.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports ID_Rs, ID_Rt  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have port ID_useRt  input  1  ID instruction reads Rt.
REQ-006 SHALL have port EX_MemR  input  1  instruction in EX is a load.
REQ-007 SHALL have port EX_dest  input  5  destination register of the instruction in EX.
REQ-008 SHALL have port branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-009 SHALL have ports mem_req, mem_ready  input  1 each  MEM-stage access active; data memory completes this cycle.
REQ-010 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register load enables.
REQ-011 SHALL have ports ifid_flush, idex_flush  output  1 each  insert bubble into IF/ID, ID/EX.
REQ-012 SHALL have ports stall_cnt, flush_cnt  output  16 each  saturating performance counters.
REQ-013 SHALL have port mem_err  output  1  sticky memory-timeout flag.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, ERR; 2-bit state register.
REQ-015 Load-use hazard SHALL be EX_MemR && EX_dest!=0 && (EX_dest==ID_Rs || (ID_useRt && EX_dest==ID_Rt)).
REQ-016 Freeze SHALL mean all five enables 0, both flushes 0.
REQ-017 RUN, mem_req && !mem_ready: freeze this cycle, next state MEM_WAIT, wait counter loaded with 1.
REQ-018 MEM_WAIT, !mem_ready: freeze, wait counter +1; when counter==TIMEOUT, next state ERR.
REQ-019 MEM_WAIT, mem_ready: all enables 1 this cycle (flushes per REQ-021/022), next state RUN.
REQ-020 Priority within RUN and the completing MEM_WAIT cycle: memory stall > branch > load-use.
REQ-021 Branch (no memory stall): all enables 1, ifid_flush=1, idex_flush=1, single cycle.
REQ-022 Load-use (no stall, no branch): pc_en=0, ifid_en=0, idex_flush=1, idex_en/exmem_en/memwb_en=1; one bubble only.
REQ-023 No condition: all enables 1, flushes 0.
REQ-024 ERR: freeze permanently; mem_err=1; exit only by rst.
REQ-025 Enables/flushes SHALL be combinational from state and inputs, same-cycle response; state, counters, mem_err registered.
REQ-026 stall_cnt SHALL increment on every rising edge with pc_en=0 outside reset, saturating at 16'hFFFF.
REQ-027 flush_cnt SHALL increment on every cycle REQ-021 applies, saturating at 16'hFFFF.
REQ-028 Hazard compare with EX_dest==0 SHALL never stall.

Reset
REQ-029 rst SHALL force state RUN, wait counter 0, stall_cnt 0, flush_cnt 0, mem_err 0 immediately, independent of clk.
REQ-030 While rst=1, all enables and flushes SHALL be 0.
REQ-031 rst asserted mid-MEM_WAIT or in ERR SHALL abandon the wait; first cycle after release behaves as RUN.

Structure
REQ-032 State encoding constants (RUN=0, MEM_WAIT=1, ERR=2) and counter width SHALL live in shared package pipe_ctrl_pkg.
REQ-033 One sub-module SHALL be natural: sat_counter16 (enable, async clear, saturate), instantiated twice.
REQ-034 Block SHALL sit alongside the EX stage and drive enables of IF/ID, ID/EX, EXE2MEM and MEM/WB registers.

Verification
REQ-035 Load-use: EX_MemR=1, EX_dest=5, ID_Rs=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
REQ-036 EX_dest=0, ID_Rs=0, EX_MemR=1 -> no stall, all enables 1.
REQ-037 branch_taken=1 with load-use hazard same cycle -> both flushes 1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
REQ-038 mem_req=1, mem_ready low 3 cycles then high -> 3 freeze cycles, release on 4th, state RUN, stall_cnt=3.
REQ-039 TIMEOUT=4, mem_ready never -> ERR after 4 wait cycles, mem_err=1 held; rst pulse -> mem_err=0, RUN.
REQ-040 Force stall_cnt to 16'hFFFE then 3 stall cycles -> stall_cnt holds 16'hFFFF.
